// File: rtl/mining_pkg.sv
// Shared types and helpers for the mining datapath.
// Holds the sweep state encoding and nonce byte-order helper.
package mining_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  // Reverses the low n bytes of v; bytes above n come back zero.
  function automatic logic [63:0] byte_rev(
    input logic [63:0] v,
    input int          n
  );
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        r[BYTE_W*(n-1-i) +: BYTE_W] = v[BYTE_W*i +: BYTE_W];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nonce_counter.sv
// Loadable nonce counter with end-of-range compare.
// last is high while the current value equals the latched end.
module nonce_counter
  import mining_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] start,
  input  logic [W-1:0] end_v,
  output logic [W-1:0] cur,
  output logic         last
);

  logic [W-1:0] end_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur   <= '0;
      end_q <= '0;
    end else if (load) begin
      cur   <= start;
      end_q <= end_v;
    end else if (inc) begin
      cur   <= cur + W'(1);
    end
  end

  assign last = (cur == end_q);

endmodule

// File: rtl/block_assembler_nonce.sv
// Latches one header and emits {header, nonce} blocks over a nonce range.
// Supports backpressure, abort, and selectable nonce byte order.
module block_assembler_nonce
  import mining_pkg::*;
#(
  parameter int HDR_BYTES   = 12,
  parameter int NONCE_BYTES = 4,
  parameter int BLK_BYTES   = HDR_BYTES + NONCE_BYTES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       hdr_valid,
  output logic                       hdr_ready,
  input  logic [HDR_BYTES*8-1:0]     hdr_data,
  input  logic [NONCE_BYTES*8-1:0]   nonce_start,
  input  logic [NONCE_BYTES*8-1:0]   nonce_end,
  input  logic                       nonce_le,
  input  logic                       abort,
  output logic                       blk_valid,
  input  logic                       blk_ready,
  output logic [BLK_BYTES*8-1:0]     blk_data,
  output logic [NONCE_BYTES*8-1:0]   blk_nonce,
  output logic                       busy,
  output logic                       done,
  output logic                       exhausted
);

  localparam int HW = HDR_BYTES * BYTE_W;
  localparam int NW = NONCE_BYTES * BYTE_W;

  state_t        state;
  state_t        state_nx;
  logic [HW-1:0] hdr_q;
  logic          le_q;
  logic [NW-1:0] cur;
  logic [NW-1:0] nonce_ord;
  logic          last;
  logic          hdr_acc;
  logic          blk_hs;
  logic          cnt_inc;

  assign hdr_acc = hdr_valid & hdr_ready;
  assign blk_hs  = blk_valid & blk_ready;
  assign cnt_inc = blk_hs & ~last & ~abort;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == IDLE: if (hdr_acc) state_nx = RUN;
      state == RUN: begin
        if ((blk_hs && last) || abort) begin
          state_nx = FIN;
        end
      end
      state == FIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    hdr_ready = reset & (state == IDLE);
    blk_valid = (state == RUN);
    done      = (state == FIN);
    busy      = (state != IDLE);
  end

  // A final handshake wins over a same-cycle abort.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hdr_q     <= '0;
      le_q      <= 1'b0;
      exhausted <= 1'b0;
    end else if (hdr_acc) begin
      hdr_q     <= hdr_data;
      le_q      <= nonce_le;
      exhausted <= 1'b0;
    end else if (blk_hs && last) begin
      exhausted <= 1'b1;
    end
  end

  nonce_counter #(
    .W(NW)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (hdr_acc),
    .inc   (cnt_inc),
    .start (nonce_start),
    .end_v (nonce_end),
    .cur   (cur),
    .last  (last)
  );

  always_comb begin
    nonce_ord = cur;
    if (le_q) begin
      nonce_ord = NW'(byte_rev(64'(cur), NONCE_BYTES));
    end
  end

  assign blk_data  = {hdr_q, nonce_ord};
  assign blk_nonce = cur;

endmodule

// File: tb/tb_block_assembler_nonce.sv
// Bench for block_assembler_nonce: directed plan cases plus random traffic
// checked every cycle against a transaction-level sweep model.
module tb_block_assembler_nonce;

  logic         clk = 1'b0;
  logic         reset;
  logic         hdr_valid;
  logic         hdr_ready;
  logic [95:0]  hdr_data;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;
  logic         nonce_le;
  logic         abort;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic [31:0]  blk_nonce;
  logic         busy;
  logic         done;
  logic         exhausted;

  always #5 clk = ~clk;

  block_assembler_nonce #(
    .HDR_BYTES  (12),
    .NONCE_BYTES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hdr_valid  (hdr_valid),
    .hdr_ready  (hdr_ready),
    .hdr_data   (hdr_data),
    .nonce_start(nonce_start),
    .nonce_end  (nonce_end),
    .nonce_le   (nonce_le),
    .abort      (abort),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready),
    .blk_data   (blk_data),
    .blk_nonce  (blk_nonce),
    .busy       (busy),
    .done       (done),
    .exhausted  (exhausted)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Sweep model: offering blocks, finishing, sticky exhausted flag.
  bit          m_active = 0;
  bit          m_done   = 0;
  bit          m_exh    = 0;
  bit          m_zero   = 1;
  bit          m_le     = 0;
  logic [31:0] m_cur    = '0;
  logic [31:0] m_end    = '0;
  logic [95:0] m_hdr    = '0;
  logic [31:0] acc[$];
  logic [31:0] ex[$];

  function automatic logic [31:0] swap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic model_edge();
    if (reset !== 1'b1) begin
      m_active = 0;
      m_done   = 0;
      m_exh    = 0;
      m_zero   = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (blk_ready && m_cur == m_end) begin
        acc.push_back(m_cur);
        m_active = 0;
        m_done   = 1;
        m_exh    = 1;
      end else begin
        if (blk_ready) begin
          acc.push_back(m_cur);
          m_cur = m_cur + 32'd1;
        end
        if (abort) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end else if (hdr_valid) begin
      m_hdr    = hdr_data;
      m_cur    = nonce_start;
      m_end    = nonce_end;
      m_le     = nonce_le;
      m_exh    = 0;
      m_zero   = 0;
      m_active = 1;
      acc.delete();
    end
  endtask

  task automatic compare();
    chk("blk_valid", blk_valid, m_active);
    chk("busy", busy, m_active | m_done);
    chk("done", done, m_done);
    chk("exhausted", exhausted, m_exh);
    chk("hdr_ready", hdr_ready, reset & ~m_active & ~m_done);
    if (m_active) begin
      chk("blk_nonce", blk_nonce, m_cur);
      chk("blk_data", blk_data,
          {m_hdr, (m_le ? swap32(m_cur) : m_cur)});
    end else if (m_zero) begin
      chk("blk_nonce_zero", blk_nonce, 0);
      chk("blk_data_zero", blk_data, 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic load(input logic [95:0] h, input logic [31:0] s,
                      input logic [31:0] e, input logic le);
    hdr_data    = h;
    nonce_start = s;
    nonce_end   = e;
    nonce_le    = le;
    hdr_valid   = 1'b1;
    step();
    hdr_valid   = 1'b0;
  endtask

  task automatic run_out(input bit stall);
    logic [3:0] pat;
    int n;
    pat = 4'b1001;
    n = 0;
    while (!m_done && n < 64) begin
      blk_ready = stall ? pat[3 - (n % 4)] : 1'b1;
      step();
      n++;
    end
    chk("sweep_timeout", m_done, 1);
  endtask

  task automatic chk_list(input string nm);
    chk({nm, "_count"}, acc.size(), ex.size());
    for (int i = 0; i < ex.size(); i++) begin
      chk(nm, (i < acc.size()) ? {96'b0, acc[i]} : 128'bx, ex[i]);
    end
  endtask

  initial begin
    reset       = 1'b0;
    hdr_valid   = 1'b0;
    hdr_data    = '0;
    nonce_start = '0;
    nonce_end   = '0;
    nonce_le    = 1'b0;
    abort       = 1'b0;
    blk_ready   = 1'b0;
    step();
    step();
    chk("rst_blk_valid", blk_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hdr_ready", hdr_ready, 0);
    chk("rst_blk_data", blk_data, 0);
    reset = 1'b1;
    step();
    chk("idle_hdr_ready", hdr_ready, 1);

    // Basic sweep 5..7
    load(96'h000102030405060708090a0b, 32'd5, 32'd7, 1'b0);
    chk("first_nonce", blk_nonce, 32'd5);
    chk("first_low", blk_data[31:0], 32'h00000005);
    chk("hdr_field", blk_data[127:32], 96'h000102030405060708090a0b);
    run_out(1'b0);
    ex.delete();
    ex.push_back(32'd5); ex.push_back(32'd6); ex.push_back(32'd7);
    chk_list("basic");
    chk("basic_done", done, 1);
    chk("basic_exh", exhausted, 1);
    step();

    // Backpressure
    load(96'h000102030405060708090a0b, 32'd5, 32'd7, 1'b0);
    run_out(1'b1);
    chk_list("stall");
    step();

    // Wrap
    load({$urandom, $urandom, $urandom}, 32'hFFFFFFFE, 32'd1, 1'b0);
    run_out(1'b0);
    ex.delete();
    ex.push_back(32'hFFFFFFFE); ex.push_back(32'hFFFFFFFF);
    ex.push_back(32'd0); ex.push_back(32'd1);
    chk_list("wrap");
    chk("wrap_exh", exhausted, 1);
    step();

    // Little-endian nonce, single block
    load(96'hA5A5, 32'h11223344, 32'h11223344, 1'b1);
    chk("le_low", blk_data[31:0], 32'h44332211);
    chk("le_nonce", blk_nonce, 32'h11223344);
    run_out(1'b0);
    ex.delete();
    ex.push_back(32'h11223344);
    chk_list("single");
    step();

    // Abort with second handshake
    load(96'h1234, 32'd0, 32'd9, 1'b0);
    blk_ready = 1'b1;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_valid", blk_valid, 0);
    chk("abort_exh", exhausted, 0);
    chk("abort_count", acc.size(), 2);
    step();
    chk("abort_hdr_ready", hdr_ready, 1);

    // Reset mid-run
    load(96'hBEEF, 32'd100, 32'd200, 1'b0);
    blk_ready = 1'b0;
    step();
    chk("pre_rst_valid", blk_valid, 1);
    reset = 1'b0;
    step();
    chk("mid_rst_valid", blk_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_nonce", blk_nonce, 0);
    chk("mid_rst_data", blk_data, 0);
    reset = 1'b1;
    step();
    load(96'hC0DE, 32'd3, 32'd3, 1'b1);
    chk("post_rst_valid", blk_valid, 1);
    chk("post_rst_low", blk_data[31:0], 32'h03000000);
    run_out(1'b0);
    step();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 199) != 0);
      hdr_valid = $urandom_range(0, 1) == 1;
      hdr_data  = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
        nonce_start = 32'hFFFFFFFF - $urandom_range(0, 3);
      end else begin
        nonce_start = $urandom;
      end
      nonce_end = nonce_start + $urandom_range(0, 6);
      nonce_le  = $urandom_range(0, 1) == 1;
      abort     = ($urandom_range(0, 19) == 0);
      blk_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
